// File: rtl/layer3_spike_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : layer3_spike_accumulator
//  Brief    : Output-layer event integrator with saturating membranes and
//             end-of-timestep argmax readout.
//  Revision : 1.0  initial release
// ============================================================================
module layer3_spike_accumulator #(
  parameter int BIT_WIDTH_WEIGHT   = 8,
  parameter int BIT_WIDTH_SRAM     = 8,
  parameter int DEPTH_SRAM         = 200,
  parameter int BIT_WIDTH_ADDRESS  = 8,
  parameter int SET_NUM            = 10,
  parameter int BIT_WIDTH_MEMBRANE = 16,
  parameter int BIT_WIDTH_CLASS    = 4
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  spike_valid_i,
  input  logic [BIT_WIDTH_ADDRESS-1:0]          spike_index_i,
  output logic                                  spike_ready_o,
  input  logic                                  timestep_end_i,
  output logic [BIT_WIDTH_ADDRESS*SET_NUM-1:0]  port1_address_o,
  output logic [SET_NUM-1:0]                    port1_enable_o,
  output logic [SET_NUM-1:0]                    port1_write_enable_o,
  output logic [BIT_WIDTH_SRAM*SET_NUM-1:0]     port1_write_data_o,
  input  logic [BIT_WIDTH_SRAM*SET_NUM-1:0]     port1_read_data_i,
  output logic [BIT_WIDTH_MEMBRANE*SET_NUM-1:0] membrane_o,
  output logic                                  result_valid_o,
  output logic [BIT_WIDTH_CLASS-1:0]            result_class_o,
  output logic [BIT_WIDTH_MEMBRANE-1:0]         result_max_o,
  output logic                                  busy_o,
  output logic                                  addr_err_o
);

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SCAN  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int c_sum_w = BIT_WIDTH_MEMBRANE + 1;
  localparam logic [BIT_WIDTH_ADDRESS:0] c_depth =
    (BIT_WIDTH_ADDRESS + 1)'(DEPTH_SRAM);
  localparam logic [BIT_WIDTH_CLASS-1:0] c_last_idx =
    BIT_WIDTH_CLASS'(SET_NUM - 1);
  localparam logic signed [BIT_WIDTH_MEMBRANE-1:0] c_mem_max =
    {1'b0, {(BIT_WIDTH_MEMBRANE - 1){1'b1}}};
  localparam logic signed [BIT_WIDTH_MEMBRANE-1:0] c_mem_min =
    {1'b1, {(BIT_WIDTH_MEMBRANE - 1){1'b0}}};

  state_t                                r_state;
  state_t                                w_next_state;
  logic                                  r_rd_pending;
  logic                                  r_addr_err;
  logic signed [BIT_WIDTH_MEMBRANE-1:0]  r_membrane [SET_NUM];
  logic signed [BIT_WIDTH_MEMBRANE-1:0]  w_acc      [SET_NUM];
  logic [BIT_WIDTH_CLASS-1:0]            r_scan_idx;
  logic signed [BIT_WIDTH_MEMBRANE-1:0]  r_best;
  logic [BIT_WIDTH_CLASS-1:0]            r_best_idx;
  logic [BIT_WIDTH_CLASS-1:0]            r_result_class;
  logic signed [BIT_WIDTH_MEMBRANE-1:0]  r_result_max;

  logic                                  w_accept;
  logic                                  w_in_range;
  logic                                  w_read;
  logic signed [BIT_WIDTH_MEMBRANE-1:0]  w_scan_val;
  logic                                  w_take;
  logic signed [BIT_WIDTH_MEMBRANE-1:0]  w_best_val;
  logic [BIT_WIDTH_CLASS-1:0]            w_best_idx;

  assign w_accept   = spike_valid_i && (r_state == ST_ACCUM);
  assign w_in_range = ({1'b0, spike_index_i} < c_depth);
  assign w_read     = w_accept && w_in_range;

  // Index 0 seeds the running best; afterwards only a strictly larger value wins.
  assign w_scan_val = r_membrane[r_scan_idx];
  assign w_take     = (r_scan_idx == '0) || (w_scan_val > r_best);
  assign w_best_val = w_take ? w_scan_val : r_best;
  assign w_best_idx = w_take ? r_scan_idx : r_best_idx;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_ACCUM: if (timestep_end_i) w_next_state = ST_DRAIN;
      ST_DRAIN: w_next_state = ST_SCAN;
      ST_SCAN:  if (r_scan_idx == c_last_idx) w_next_state = ST_DONE;
      ST_DONE:  w_next_state = ST_ACCUM;
      default:  w_next_state = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_ACCUM;
      r_rd_pending   <= 1'b0;
      r_addr_err     <= 1'b0;
      r_scan_idx     <= '0;
      r_best         <= '0;
      r_best_idx     <= '0;
      r_result_class <= '0;
      r_result_max   <= '0;
      for (int k = 0; k < SET_NUM; k++) r_membrane[k] <= '0;
    end else begin
      r_state      <= w_next_state;
      r_rd_pending <= w_read;
      if (w_accept && !w_in_range) r_addr_err <= 1'b1;

      case (r_state)
        ST_DRAIN: r_scan_idx <= '0;
        ST_SCAN: begin
          r_scan_idx <= r_scan_idx + 1'b1;
          r_best     <= w_best_val;
          r_best_idx <= w_best_idx;
          if (r_scan_idx == c_last_idx) begin
            r_result_class <= w_best_idx;
            r_result_max   <= w_best_val;
          end
        end
        default: ;
      endcase

      // No read can be pending in DONE, so clearing never loses an update.
      for (int k = 0; k < SET_NUM; k++) begin
        if (r_state == ST_DONE)  r_membrane[k] <= '0;
        else if (r_rd_pending)   r_membrane[k] <= w_acc[k];
      end
    end
  end

  for (genvar k = 0; k < SET_NUM; k++) begin : g_lane
    logic signed [BIT_WIDTH_WEIGHT-1:0] w_weight;
    logic signed [c_sum_w-1:0]          w_sum;

    assign w_weight = port1_read_data_i[k*BIT_WIDTH_SRAM +: BIT_WIDTH_WEIGHT];
    assign w_sum    = c_sum_w'(r_membrane[k]) + c_sum_w'(w_weight);
    assign w_acc[k] = (w_sum[c_sum_w-1] != w_sum[c_sum_w-2])
                      ? (w_sum[c_sum_w-1] ? c_mem_min : c_mem_max)
                      : w_sum[BIT_WIDTH_MEMBRANE-1:0];

    assign membrane_o[k*BIT_WIDTH_MEMBRANE +: BIT_WIDTH_MEMBRANE]     = r_membrane[k];
    assign port1_address_o[k*BIT_WIDTH_ADDRESS +: BIT_WIDTH_ADDRESS] = spike_index_i;
  end

  assign port1_enable_o       = {SET_NUM{w_read}};
  assign port1_write_enable_o = '0;
  assign port1_write_data_o   = '0;

  assign spike_ready_o  = (r_state == ST_ACCUM);
  assign busy_o         = (r_state != ST_ACCUM);
  assign result_valid_o = (r_state == ST_DONE);
  assign result_class_o = r_result_class;
  assign result_max_o   = r_result_max;
  assign addr_err_o     = r_addr_err;

endmodule
`default_nettype wire

// File: tb/tb_layer3_spike_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_layer3_spike_accumulator
//  Brief    : Directed scoreboard bench for layer3_spike_accumulator.
//  Revision : 1.0  initial release
// ============================================================================
module tb_layer3_spike_accumulator;

  localparam int c_set   = 10;
  localparam int c_aw    = 8;
  localparam int c_sw    = 8;
  localparam int c_mw    = 16;
  localparam int c_cw    = 4;
  localparam int c_depth = 200;

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic                    spike_valid_i;
  logic [c_aw-1:0]         spike_index_i;
  logic                    spike_ready_o;
  logic                    timestep_end_i;
  logic [c_aw*c_set-1:0]   port1_address_o;
  logic [c_set-1:0]        port1_enable_o;
  logic [c_set-1:0]        port1_write_enable_o;
  logic [c_sw*c_set-1:0]   port1_write_data_o;
  logic [c_sw*c_set-1:0]   port1_read_data_i;
  logic [c_mw*c_set-1:0]   membrane_o;
  logic                    result_valid_o;
  logic [c_cw-1:0]         result_class_o;
  logic [c_mw-1:0]         result_max_o;
  logic                    busy_o;
  logic                    addr_err_o;

  layer3_spike_accumulator #(
    .BIT_WIDTH_WEIGHT(8), .BIT_WIDTH_SRAM(c_sw), .DEPTH_SRAM(c_depth),
    .BIT_WIDTH_ADDRESS(c_aw), .SET_NUM(c_set), .BIT_WIDTH_MEMBRANE(c_mw),
    .BIT_WIDTH_CLASS(c_cw)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .spike_valid_i(spike_valid_i), .spike_index_i(spike_index_i),
    .spike_ready_o(spike_ready_o), .timestep_end_i(timestep_end_i),
    .port1_address_o(port1_address_o), .port1_enable_o(port1_enable_o),
    .port1_write_enable_o(port1_write_enable_o),
    .port1_write_data_o(port1_write_data_o),
    .port1_read_data_i(port1_read_data_i), .membrane_o(membrane_o),
    .result_valid_o(result_valid_o), .result_class_o(result_class_o),
    .result_max_o(result_max_o), .busy_o(busy_o), .addr_err_o(addr_err_o)
  );

  always #5 clk = ~clk;

  // Weight SRAM banks, one-cycle read latency
  logic [c_sw-1:0] wmem  [c_set][c_depth];
  logic [c_sw-1:0] rdata [c_set];

  always @(posedge clk)
    for (int k = 0; k < c_set; k++)
      if (port1_enable_o[k]) rdata[k] <= wmem[k][port1_address_o[k*c_aw +: c_aw]];

  always_comb begin
    port1_read_data_i = '0;
    for (int k = 0; k < c_set; k++) port1_read_data_i[k*c_sw +: c_sw] = rdata[k];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cls; int mx; int at; } exp_t;
  exp_t sbq[$];
  int   exp_mem [c_set];
  int   last_end;
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic logic signed [31:0] mem_lane(input int k);
    return $signed(membrane_o[k*c_mw +: c_mw]);
  endfunction

  task automatic model_spike(input int idx);
    int w;
    if (idx < c_depth)
      for (int k = 0; k < c_set; k++) begin
        w = $signed(wmem[k][idx]);
        exp_mem[k] = sat(exp_mem[k] + w);
      end
  endtask

  task automatic push_result();
    exp_t e;
    e.cls = 0;
    e.mx  = exp_mem[0];
    for (int k = 1; k < c_set; k++)
      if (exp_mem[k] > e.mx) begin e.mx = exp_mem[k]; e.cls = k; end
    e.at     = cyc + 12;
    last_end = cyc;
    sbq.push_back(e);
    for (int k = 0; k < c_set; k++) exp_mem[k] = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_mem(input string tag);
    for (int k = 0; k < c_set; k++) chk($sformatf("%s_mem%0d", tag, k), mem_lane(k), exp_mem[k]);
  endtask

  // Drive one spike (optionally with timestep_end) for a single cycle
  task automatic spike(input int idx, input bit with_end);
    spike_valid_i  = 1'b1;
    spike_index_i  = idx[c_aw-1:0];
    timestep_end_i = with_end;
    model_spike(idx);
    if (with_end) push_result();
    @(negedge clk);
    chk("spike_enable", port1_enable_o, (idx < c_depth) ? 32'h3FF : 32'h0);
    if (idx < c_depth) begin
      chk("addr_lane0", port1_address_o[0 +: c_aw], idx);
      chk("addr_lane9", port1_address_o[9*c_aw +: c_aw], idx);
    end
    tick(1);
    spike_valid_i  = 1'b0;
    timestep_end_i = 1'b0;
  endtask

  task automatic end_pulse();
    timestep_end_i = 1'b1;
    push_result();
    tick(1);
    timestep_end_i = 1'b0;
  endtask

  // Called in the cycle after the timestep end was accepted
  task automatic wait_done();
    int n = 0;
    chk("drain_busy", busy_o, 1);
    chk("drain_ready", spike_ready_o, 0);
    while (spike_ready_o !== 1'b1 && n < 40) begin tick(1); n++; end
    chk("ready_return_cycle", cyc, last_end + 13);
    check_mem("cleared");
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (reset_n === 1'b1 && result_valid_o === 1'b1) begin
      n_cmp++;
      assert (sbq.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_result: observed valid at cycle %0d, expected none", cyc);
      end
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("result_class", result_class_o, e.cls);
        chk("result_max", $signed(result_max_o), e.mx);
        chk("result_cycle", cyc, e.at);
      end
    end
  end

  initial begin
    for (int k = 0; k < c_set; k++) begin
      exp_mem[k] = 0;
      for (int a = 0; a < c_depth; a++) wmem[k][a] = 8'($urandom);
      wmem[k][0] = 8'h7F;
      wmem[k][1] = 8'h80;
      wmem[k][2] = 8'h11;
      wmem[k][5] = 8'(k + 1);
    end
    reset_n = 1'b0; spike_valid_i = 1'b0; spike_index_i = '0; timestep_end_i = 1'b0;
    tick(3);
    @(negedge clk);
    chk("rst_ready", spike_ready_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_valid", result_valid_o, 0);
    chk("rst_class", result_class_o, 0);
    chk("rst_max", result_max_o, 0);
    chk("rst_addr_err", addr_err_o, 0);
    chk("rst_enable", port1_enable_o, 0);
    chk("rst_wen", port1_write_enable_o, 0);
    chk("rst_wdata_nonzero", (port1_write_data_o != '0), 0);
    check_mem("rst");
    tick(1);
    reset_n = 1'b1;
    tick(1);

    // Three back-to-back spikes at address 5
    for (int i = 0; i < 3; i++) spike(5, 1'b0);
    tick(1);
    check_mem("three5");
    end_pulse();
    wait_done();

    // Positive saturation
    for (int i = 0; i < 300; i++) spike(0, 1'b0);
    tick(1);
    check_mem("satpos");
    end_pulse();
    wait_done();

    // Negative saturation
    for (int i = 0; i < 300; i++) spike(1, 1'b0);
    tick(1);
    check_mem("satneg");
    end_pulse();
    wait_done();

    // Equal weights: tie resolves to lowest index; also checks update latency
    spike(2, 1'b0);
    chk("lat_t1", mem_lane(0), 0);
    tick(1);
    chk("lat_t2", mem_lane(0), 17);
    end_pulse();
    wait_done();

    // Out-of-range index is dropped and flagged
    spike(200, 1'b0);
    chk("addr_err_set", addr_err_o, 1);
    tick(1);
    check_mem("dropped");
    spike(5, 1'b0);
    tick(1);
    chk("addr_err_sticky", addr_err_o, 1);
    check_mem("after_drop");
    end_pulse();
    wait_done();

    // Spike accepted together with timestep end belongs to that timestep
    spike(5, 1'b1);
    wait_done();

    // Random spike train with idle gaps
    for (int i = 0; i < 30; i++) begin
      spike(int'($urandom_range(0, c_depth - 1)), 1'b0);
      tick(int'($urandom_range(0, 2)));
    end
    tick(1);
    check_mem("random");
    end_pulse();
    wait_done();

    // Reset asserted during SCAN aborts the result
    spike(5, 1'b0);
    tick(1);
    end_pulse();
    tick(4);
    reset_n = 1'b0;
    void'(sbq.pop_back());
    for (int k = 0; k < c_set; k++) exp_mem[k] = 0;
    #1;
    chk("midrst_ready", spike_ready_o, 1);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_valid", result_valid_o, 0);
    chk("midrst_class", result_class_o, 0);
    chk("midrst_max", result_max_o, 0);
    chk("midrst_addr_err", addr_err_o, 0);
    check_mem("midrst");
    tick(1);
    reset_n = 1'b1;
    tick(20);
    chk("postrst_busy", busy_o, 0);
    chk("postrst_queue", sbq.size(), 0);
    spike(5, 1'b0);
    tick(1);
    check_mem("postrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/layer3_spike_accumulator.md
# layer3_spike_accumulator

Event-driven integrator for the output layer. Accepts presynaptic spike indices, reads one weight per output neuron in parallel from the layer-3 weight SRAM set (SET_NUM banks, one read port each, 1-cycle read latency), and accumulates the signed weights into SET_NUM saturating membrane registers. On a timestep-end pulse it drains the pipeline, scans the membranes for the argmax class, reports the result, and clears the membranes for the next timestep.

## Interface
Parameters:
- BIT_WIDTH_WEIGHT, 8, signed weight width (equals BIT_WIDTH_SRAM)
- BIT_WIDTH_SRAM, 8, SRAM word width
- DEPTH_SRAM, 200, words per bank; valid spike indices are 0..DEPTH_SRAM-1
- BIT_WIDTH_ADDRESS, 8, SRAM address and spike index width
- SET_NUM, 10, number of output neurons / SRAM banks
- BIT_WIDTH_MEMBRANE, 16, signed membrane width
- BIT_WIDTH_CLASS, 4, class index width (at least clog2(SET_NUM))

Ports (one clock `clk`; reset `reset_n` is asynchronous, active-low):
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- spike_valid_i  input  1  spike index present
- spike_index_i  input  BIT_WIDTH_ADDRESS  presynaptic neuron index
- spike_ready_o  output  1  spike accepted when valid & ready
- timestep_end_i  input  1  single-cycle pulse, ends the timestep
- port1_address_o  output  BIT_WIDTH_ADDRESS*SET_NUM  per-bank address (all lanes equal)
- port1_enable_o  output  SET_NUM  per-bank enable
- port1_write_enable_o  output  SET_NUM  tied 0
- port1_write_data_o  output  BIT_WIDTH_SRAM*SET_NUM  tied 0
- port1_read_data_i  input  BIT_WIDTH_SRAM*SET_NUM  bank read data, valid 1 cycle after enable
- membrane_o  output  BIT_WIDTH_MEMBRANE*SET_NUM  current membrane values; lane k = neuron k
- result_valid_o  output  1  single-cycle pulse, result fields updated
- result_class_o  output  BIT_WIDTH_CLASS  argmax neuron index, held until next result
- result_max_o  output  BIT_WIDTH_MEMBRANE  argmax membrane value, held
- busy_o  output  1  high in DRAIN/SCAN/DONE
- addr_err_o  output  1  sticky, out-of-range spike seen

## Operation
- FSM states: ACCUM, DRAIN, SCAN, DONE. Reset state is ACCUM.
- ACCUM: spike_ready_o = 1. An accepted spike with index < DEPTH_SRAM drives port1_enable_o = all ones and every address lane = index in the same cycle (combinational from the inputs). It also sets the registered rd_pending flag.
- A spike with index >= DEPTH_SRAM is accepted but dropped: no enable, no pending, addr_err_o set.
- Cycle after a read (rd_pending = 1), in any state: for each k, membrane[k] += sign_extend(read_data[k]), clamped to [-2^(BIT_WIDTH_MEMBRANE-1), 2^(BIT_WIDTH_MEMBRANE-1)-1]. Reads never stall, so throughput is one spike per cycle.
- timestep_end_i in ACCUM -> DRAIN. If a spike is accepted in the same cycle, it belongs to the ending timestep. timestep_end_i outside ACCUM is ignored.
- DRAIN (1 cycle): spike_ready_o = 0; the pending accumulate completes. Go to SCAN with scan index 0, best = membrane[0], best index 0.
- SCAN: one neuron per cycle, indices 0..SET_NUM-1. Replace best only on a strictly greater value, so ties resolve to the lowest index. After index SET_NUM-1, go to DONE.
- DONE (1 cycle): result_valid_o = 1, result_class_o/result_max_o = best. All membranes are cleared to 0 at the clock edge ending DONE. Then go to ACCUM.
- port1_write_enable_o and port1_write_data_o are constant 0.

## Timing
- Reset values: all membranes 0, result_valid_o 0, result_class_o 0, result_max_o 0, busy_o 0, addr_err_o 0, spike_ready_o 1 (state ACCUM), port1_enable_o 0, rd_pending 0.
- Spike accepted at cycle t: SRAM read edge ends t, data valid in t+1, membrane updated at the edge ending t+1, visible on membrane_o in t+2.
- timestep_end_i accepted at T: DRAIN at T+1, SCAN at T+2..T+1+SET_NUM, DONE with result_valid_o high at T+2+SET_NUM (T+12 for SET_NUM=10). spike_ready_o is high again at T+3+SET_NUM, with membranes reading 0.
- Reset asserted mid-operation: immediate return to reset values, and any pending read is discarded.

## Test plan
- Weights bank k at address 5 = k+1. Spikes 5,5,5 back-to-back, then end -> membrane[k] = 3(k+1), result_class 9, result_max 30, result_valid at end+12.
- Weight 0x7F at address 0, all banks; 300 spikes of index 0 -> membranes saturate at 32767, no wrap.
- Weight 0x80 (-128) at address 1; 300 spikes -> membranes clamp at -32768.
- All weights equal at address 2; one spike, then end -> result_class 0 (lowest-index tie).
- Spike index 200 -> port1_enable_o stays 0, addr_err_o = 1 and sticky; membranes unchanged.
- Spike and timestep_end in the same cycle -> that spike is included in the result. Reset pulsed during SCAN -> result_valid never fires, all outputs at reset values.
